// File: rtl/alien_formation.sv
// Marching alien formation: steps the 10x5 grid left/right, drops at the edges and flags invasion.
// Optional FORMATION_SPEEDUP_EN: step interval shrinks with the number of live aliens.
module alien_formation #(
    parameter int START_COL     = 100,
    parameter int START_ROW     = 40,
    parameter int STEP_X        = 10,
    parameter int STEP_Y        = 10,
    parameter int LEFT_LIMIT    = 10,
    parameter int RIGHT_LIMIT   = 630,
    parameter int INVADE_ROW    = 440,
    parameter int BASE_INTERVAL = 26
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Frame_Tick,
    input  logic        Enable,
    input  logic        Restart,
    input  logic [49:0] Aliens_Grid,
    output logic [8:0]  Aliens_Row,
    output logic [9:0]  Aliens_Col,
    output logic        Direction,
    output logic        Move_Pulse,
    output logic        Invaded
);

    localparam int N_COLS  = 10;
    localparam int N_ROWS  = 5;
    localparam int PITCH_X = 40;
    localparam int PITCH_Y = 30;
    localparam int ALIEN_W = 30;
    localparam int ALIEN_H = 20;

    typedef enum logic [1:0] {MARCH_R, MARCH_L, HALT} state_t;

    state_t      state;
    logic [7:0]  frame_cnt;
    logic [7:0]  interval;
    logic [9:0]  col_live;
    logic [4:0]  row_live;
    logic [3:0]  lmin;
    logic [3:0]  rmax;
    logic [2:0]  bmax;
    logic [10:0] right_edge;
    logic [10:0] left_edge;
    logic [10:0] bottom_edge;
    logic        grid_empty;
    logic        invade_hit;
    logic        tick_en;
    logic        step;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        col_live = '0;
        row_live = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++) begin
                if (Aliens_Grid[r*N_COLS + c]) begin
                    col_live[c] = 1'b1;
                    row_live[r] = 1'b1;
                end
            end
        end
    end

    // Scan order picks the extreme index: descending scan leaves the lowest, ascending the highest.
    always_comb begin
        lmin = '0;
        rmax = '0;
        bmax = '0;
        for (int c = N_COLS - 1; c >= 0; c--) begin
            if (col_live[c]) lmin = 4'(c);
        end
        for (int c = 0; c < N_COLS; c++) begin
            if (col_live[c]) rmax = 4'(c);
        end
        for (int r = 0; r < N_ROWS; r++) begin
            if (row_live[r]) bmax = 3'(r);
        end
    end

`ifdef FORMATION_SPEEDUP_EN
    logic [5:0] live_count;

    always_comb begin
        live_count = '0;
        for (int i = 0; i < N_COLS*N_ROWS; i++) begin
            if (Aliens_Grid[i]) live_count = live_count + 6'd1;
        end
    end

    assign interval = 8'd1 + {3'd0, live_count[5:1]};
`else
    assign interval = 8'(BASE_INTERVAL);
`endif

    // 11-bit sums leave headroom so a formation near the right edge cannot wrap the compare.
    assign right_edge  = {1'b0, Aliens_Col} + 11'(rmax) * 11'(PITCH_X) + 11'(ALIEN_W + STEP_X);
    assign left_edge   = {1'b0, Aliens_Col} + 11'(lmin) * 11'(PITCH_X);
    assign bottom_edge = {2'b0, Aliens_Row} + 11'(bmax) * 11'(PITCH_Y) + 11'(ALIEN_H);

    assign grid_empty = (Aliens_Grid == '0);
    assign invade_hit = !grid_empty && (bottom_edge >= 11'(INVADE_ROW));
    assign tick_en    = Frame_Tick && Enable && (state != HALT);
    // A shrinking interval can leave the counter above the new limit, hence >= rather than ==.
    assign step       = tick_en && (frame_cnt >= interval - 8'd1);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= MARCH_R;
            Direction  <= 1'b1;
            Aliens_Row <= 9'(START_ROW);
            Aliens_Col <= 10'(START_COL);
            frame_cnt  <= '0;
            Move_Pulse <= 1'b0;
            Invaded    <= 1'b0;
        end else if (Restart) begin
            state      <= MARCH_R;
            Direction  <= 1'b1;
            Aliens_Row <= 9'(START_ROW);
            Aliens_Col <= 10'(START_COL);
            frame_cnt  <= '0;
            Move_Pulse <= 1'b0;
            Invaded    <= 1'b0;
        end else begin
            Move_Pulse <= 1'b0;
            if (invade_hit) begin
                Invaded   <= 1'b1;
                state     <= HALT;
                Direction <= 1'b0;
            end else if (grid_empty) begin
                state     <= HALT;
                Direction <= 1'b0;
            end else if (step) begin
                frame_cnt  <= '0;
                Move_Pulse <= 1'b1;
                if (state == MARCH_R) begin
                    if (right_edge > 11'(RIGHT_LIMIT)) begin
                        Aliens_Row <= Aliens_Row + 9'(STEP_Y);
                        state      <= MARCH_L;
                        Direction  <= 1'b0;
                    end else begin
                        Aliens_Col <= Aliens_Col + 10'(STEP_X);
                    end
                end else begin
                    if (left_edge < 11'(LEFT_LIMIT + STEP_X)) begin
                        Aliens_Row <= Aliens_Row + 9'(STEP_Y);
                        state      <= MARCH_R;
                        Direction  <= 1'b1;
                    end else begin
                        Aliens_Col <= Aliens_Col - 10'(STEP_X);
                    end
                end
            end else if (tick_en) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alien_formation.sv
// Directed self-checking bench for alien_formation: timing, edge drops, invasion, restart, reset.
// Instance a uses default parameters; instance b starts near the bottom-right to reach invasion quickly.
module tb_alien_formation;

`ifdef FORMATION_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Frame_Tick;
    logic        enable_a, enable_b;
    logic        restart_a, restart_b;
    logic [49:0] grid_a, grid_b;
    logic [8:0]  row_a, row_b;
    logic [9:0]  col_a, col_b;
    logic        dir_a, dir_b, move_a, move_b, inv_a, inv_b;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    alien_formation dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .Frame_Tick(Frame_Tick), .Enable(enable_a),
        .Restart(restart_a), .Aliens_Grid(grid_a), .Aliens_Row(row_a), .Aliens_Col(col_a),
        .Direction(dir_a), .Move_Pulse(move_a), .Invaded(inv_a)
    );

    alien_formation #(.START_COL(240), .START_ROW(410)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .Frame_Tick(Frame_Tick), .Enable(enable_b),
        .Restart(restart_b), .Aliens_Grid(grid_b), .Aliens_Row(row_b), .Aliens_Col(col_b),
        .Direction(dir_b), .Move_Pulse(move_b), .Invaded(inv_b)
    );

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int exp_interval(input logic [49:0] g);
        return SPEEDUP ? 1 + ($countones(g) >> 1) : 26;
    endfunction

    // One frame tick; pulses are sampled at the negedge after the capturing posedge.
    task automatic tick(input logic with_restart, output logic pa, output logic pb);
        @(negedge Clk);
        Frame_Tick = 1'b1;
        restart_a  = with_restart;
        @(negedge Clk);
        Frame_Tick = 1'b0;
        restart_a  = 1'b0;
        pa = move_a;
        pb = move_b;
    endtask

    // Ticks until the selected instance strobes Move_Pulse; bounded so a dead DUT cannot hang.
    task automatic step_dut(input string tag, input bit sel_b, input int exp_ticks);
        logic pa, pb;
        int   n = 0;
        for (int i = 1; i <= 80 && n == 0; i++) begin
            tick(1'b0, pa, pb);
            if (sel_b ? pb : pa) n = i;
        end
        check({tag, " ticks"}, 64'(n), 64'(exp_ticks));
    endtask

    task automatic idle_ticks(input string tag, input bit sel_b, input int count);
        logic pa, pb;
        int   pulses = 0;
        for (int i = 0; i < count; i++) begin
            tick(1'b0, pa, pb);
            if (sel_b ? pb : pa) pulses++;
        end
        check({tag, " pulses"}, 64'(pulses), 64'd0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        logic        pa, pb;
        logic [49:0] left_half;
        int          exp_col;

        Frame_Tick = 1'b0;
        enable_a   = 1'b1;
        enable_b   = 1'b0;
        restart_a  = 1'b0;
        restart_b  = 1'b0;
        grid_a     = '1;
        grid_b     = 50'h3FF;
        left_half  = '0;
        for (int r = 0; r < 5; r++) left_half[r*10 +: 5] = 5'h1F;
        do_reset();

        check("rst row", 64'(row_a), 64'd40);
        check("rst col", 64'(col_a), 64'd100);
        check("rst dir", 64'(dir_a), 64'd1);
        check("rst move", 64'(move_a), 64'd0);
        check("rst inv", 64'(inv_a), 64'd0);
        check("rst b row", 64'(row_b), 64'd410);
        check("rst b col", 64'(col_b), 64'd240);
        check("rst b inv", 64'(inv_b), 64'd0);

        step_dut("first step", 1'b0, exp_interval(grid_a));
        check("first step col", 64'(col_a), 64'd110);
        check("first step row", 64'(row_a), 64'd40);
        @(negedge Clk);
        check("pulse width", 64'(move_a), 64'd0);

        enable_a = 1'b0;
        idle_ticks("disabled", 1'b0, 30);
        check("disabled col", 64'(col_a), 64'd110);
        enable_a = 1'b1;

        // Async reset mid-interval: outputs clear before any edge, pending count is lost.
        for (int i = 0; i < 20; i++) tick(1'b0, pa, pb);
        #2 Reset_n = 1'b0;
        #1 check("async rst col", 64'(col_a), 64'd100);
        @(negedge Clk);
        Reset_n = 1'b1;
        step_dut("post rst step", 1'b0, exp_interval(grid_a));
        check("post rst col", 64'(col_a), 64'd110);

        do_reset();
        for (int i = 0; i < exp_interval(grid_a) - 1; i++) tick(1'b0, pa, pb);
        check("pre restart col", 64'(col_a), 64'd100);
        tick(1'b1, pa, pb);
        check("restart move", 64'(pa), 64'd0);
        check("restart row", 64'(row_a), 64'd40);
        check("restart col", 64'(col_a), 64'd100);
        check("restart dir", 64'(dir_a), 64'd1);
        step_dut("after restart", 1'b0, exp_interval(grid_a));
        check("after restart col", 64'(col_a), 64'd110);

        // Full grid: right edge 240+360+30+10=640 > 630 drops; 230 gives 630 which still steps.
        for (exp_col = 120; exp_col <= 240; exp_col += 10) begin
            step_dut("march r", 1'b0, exp_interval(grid_a));
            check("march r col", 64'(col_a), 64'(exp_col));
        end
        check("march r row", 64'(row_a), 64'd40);
        step_dut("drop r", 1'b0, exp_interval(grid_a));
        check("drop r row", 64'(row_a), 64'd50);
        check("drop r col", 64'(col_a), 64'd240);
        check("drop r dir", 64'(dir_a), 64'd0);

        // Left edge: Col < 20 drops, so Col 10 is the last position reached.
        for (exp_col = 230; exp_col >= 10; exp_col -= 10) begin
            step_dut("march l", 1'b0, exp_interval(grid_a));
            check("march l col", 64'(col_a), 64'(exp_col));
        end
        step_dut("drop l", 1'b0, exp_interval(grid_a));
        check("drop l row", 64'(row_a), 64'd60);
        check("drop l col", 64'(col_a), 64'd10);
        check("drop l dir", 64'(dir_a), 64'd1);

        // Columns 0..4 only: Rmax=4, drop once Col+160+40 > 630, i.e. at Col 440.
        grid_a = left_half;
        for (exp_col = 20; exp_col <= 440; exp_col += 10) begin
            step_dut("half r", 1'b0, exp_interval(grid_a));
            check("half r col", 64'(col_a), 64'(exp_col));
        end
        step_dut("half drop", 1'b0, exp_interval(grid_a));
        check("half drop row", 64'(row_a), 64'd70);
        check("half drop col", 64'(col_a), 64'd440);
        check("half drop dir", 64'(dir_a), 64'd0);

        grid_a = '0;
        repeat (2) @(negedge Clk);
        check("empty dir", 64'(dir_a), 64'd0);
        check("empty inv", 64'(inv_a), 64'd0);
        idle_ticks("empty halt", 1'b0, 30);
        check("empty col", 64'(col_a), 64'd440);
        enable_a = 1'b0;

        // Row 410, row 1 live: 410+30+20=460 >= 440 invades.
        grid_b = 50'h3FF << 10;
        repeat (2) @(negedge Clk);
        check("inv set", 64'(inv_b), 64'd1);
        check("inv halt dir", 64'(dir_b), 64'd0);
        enable_b = 1'b1;
        idle_ticks("inv halt", 1'b1, 30);
        check("inv halt row", 64'(row_b), 64'd410);

        grid_b = 50'h3FF;
        @(negedge Clk);
        restart_b = 1'b1;
        @(negedge Clk);
        restart_b = 1'b0;
        check("b restart inv", 64'(inv_b), 64'd0);
        check("b restart row", 64'(row_b), 64'd410);
        check("b restart dir", 64'(dir_b), 64'd1);
        @(negedge Clk);
        check("row0 no inv", 64'(inv_b), 64'd0);

        // Drop to row 420 with only row 0 live: 420+20=440 meets the limit exactly.
        step_dut("b drop", 1'b1, exp_interval(grid_b));
        check("b drop row", 64'(row_b), 64'd420);
        check("b drop col", 64'(col_b), 64'd240);
        check("b drop inv lag", 64'(inv_b), 64'd0);
        @(negedge Clk);
        check("boundary inv", 64'(inv_b), 64'd1);
        idle_ticks("boundary halt", 1'b1, 30);
        check("boundary row", 64'(row_b), 64'd420);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
